// File: rtl/frame_buffer_loader_if.sv
// Pixel stream and ping-pong buffer write bus for the frame buffer loader.
// master: upstream source plus display-side status; slave: the loader itself.
interface frame_buffer_loader_if #(
   parameter int unsigned ADDR_W = 20
);
   // Upstream pixel stream
   logic [31:0]       PxData;
   logic              PxValid;
   logic              PxReady;

   // Display-side buffer status levels
   logic              Buf0Empty;
   logic              Buf1Empty;

   // Buffer write port
   logic [31:0]       WData;
   logic [ADDR_W-1:0] Addrw0;
   logic [ADDR_W-1:0] Addrw1;
   logic              WE0;
   logic              WE1;

   // Fill status
   logic              Buf0Full;
   logic              Buf1Full;
   logic [15:0]       FrameCount;

   modport master (
      output PxData, PxValid, Buf0Empty, Buf1Empty,
      input  PxReady, WData, Addrw0, Addrw1, WE0, WE1, Buf0Full, Buf1Full, FrameCount
   );

   modport slave (
      input  PxData, PxValid, Buf0Empty, Buf1Empty,
      output PxReady, WData, Addrw0, Addrw1, WE0, WE1, Buf0Full, Buf1Full, FrameCount
   );
endinterface

// File: rtl/frame_buffer_loader.sv
// Producer side of the ping-pong pixel buffers: accepts a valid/ready pixel stream and
// writes whole frames alternately into Buf0 and Buf1, starting a fill only when the
// display reports the selected buffer empty and has released it since its last fill.
module frame_buffer_loader #(
   parameter int unsigned ADDR_W        = 20,
   parameter int unsigned WORDS_PER_BUF = 307200
) (
   input logic                  clk,
   input logic                  reset,
   frame_buffer_loader_if.slave bus
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(WORDS_PER_BUF - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill0 = 2'd1,
      StFill1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              next_buf_q, next_buf_d;
   logic              armed0_q, armed0_d;
   logic              armed1_q, armed1_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;

   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] addrw0_q, addrw0_d;
   logic [ADDR_W-1:0] addrw1_q, addrw1_d;
   logic              we0_q, we0_d;
   logic              we1_q, we1_d;
   logic              full0_q, full0_d;
   logic              full1_q, full1_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic              px_ready;
   logic              xfer;
   logic              last_word;

   // Ready is a pure decode of the registered state: no path from PxValid.
   assign px_ready  = (state_q == StFill0) || (state_q == StFill1);
   assign xfer      = bus.PxValid & px_ready;
   assign last_word = (word_cnt_q == LastIdx);

   // Next-state and write-port logic
   always_comb begin
      state_d     = state_q;
      next_buf_d  = next_buf_q;
      // A low Empty means the display has taken the buffer; only then may it be refilled.
      armed0_d    = armed0_q | ~bus.Buf0Empty;
      armed1_d    = armed1_q | ~bus.Buf1Empty;
      word_cnt_d  = word_cnt_q;
      wdata_d     = wdata_q;
      addrw0_d    = addrw0_q;
      addrw1_d    = addrw1_q;
      we0_d       = 1'b0;
      we1_d       = 1'b0;
      full0_d     = 1'b0;
      full1_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         StIdle: begin
            // Only the buffer next in turn is considered, even if the other is empty.
            if (!next_buf_q && bus.Buf0Empty && armed0_q) begin
               state_d = StFill0;
            end else if (next_buf_q && bus.Buf1Empty && armed1_q) begin
               state_d = StFill1;
            end
         end

         StFill0, StFill1: begin
            if (xfer) begin
               wdata_d = bus.PxData;
               if (state_q == StFill0) begin
                  addrw0_d = word_cnt_q;
                  we0_d    = 1'b1;
               end else begin
                  addrw1_d = word_cnt_q;
                  we1_d    = 1'b1;
               end

               if (last_word) begin
                  state_d     = StIdle;
                  word_cnt_d  = '0;
                  next_buf_d  = ~next_buf_q;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  // Disarm wins over a same-cycle re-arm so a stale Empty cannot refill.
                  if (state_q == StFill0) begin
                     armed0_d = 1'b0;
                     full0_d  = 1'b1;
                  end else begin
                     armed1_d = 1'b0;
                     full1_d  = 1'b1;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + ADDR_W'(1);
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         next_buf_q  <= 1'b0;
         armed0_q    <= 1'b1;
         armed1_q    <= 1'b1;
         word_cnt_q  <= '0;
         wdata_q     <= '0;
         addrw0_q    <= '0;
         addrw1_q    <= '0;
         we0_q       <= 1'b0;
         we1_q       <= 1'b0;
         full0_q     <= 1'b0;
         full1_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         next_buf_q  <= next_buf_d;
         armed0_q    <= armed0_d;
         armed1_q    <= armed1_d;
         word_cnt_q  <= word_cnt_d;
         wdata_q     <= wdata_d;
         addrw0_q    <= addrw0_d;
         addrw1_q    <= addrw1_d;
         we0_q       <= we0_d;
         we1_q       <= we1_d;
         full0_q     <= full0_d;
         full1_q     <= full1_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.PxReady    = px_ready;
   assign bus.WData      = wdata_q;
   assign bus.Addrw0     = addrw0_q;
   assign bus.Addrw1     = addrw1_q;
   assign bus.WE0        = we0_q;
   assign bus.WE1        = we1_q;
   assign bus.Buf0Full   = full0_q;
   assign bus.Buf1Full   = full1_q;
   assign bus.FrameCount = frame_cnt_q;

endmodule
